frp_stream_encoder: RTL and testbench

FRP_STREAM_ENCODER -- requirements
Module: frp_stream_encoder

---
 rtl/frp_stream_encoder.sv | 151 +++++++++++++++
 tb/tb_frp_stream_encoder.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frp_stream_encoder.sv
// Symbol stream encoder: balances pol bits against a running disparity, optional differential rotation.
// First beat one cycle after accept; serial or parallel beats under valid/ready, outputs hold while stalled.
module frp_stream_encoder #(
    parameter int NSYM     = 7,
    parameter int DIFF_ROT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2*NSYM-1:0] Tx_Data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              par_mode,
    input  logic              rd_clr,
    output logic [NSYM-1:0]   Tx_Flip,
    output logic [NSYM-1:0]   Tx_Rotation,
    output logic [NSYM-1:0]   Tx_Polarity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [3:0]        sym_idx
);
    localparam logic signed [1:0] RD_POS   = 2'sb01;
    localparam logic signed [1:0] RD_NEG   = 2'sb11;
    localparam logic [3:0]        LAST_IDX = 4'(NSYM - 1);

    logic [2*NSYM-1:0] data_q, data_d;
    logic              mode_q, mode_d;
    logic [3:0]        idx_q, idx_d;
    logic signed [1:0] rd_q, rd_d;
    logic              prev_rot_q, prev_rot_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [NSYM-1:0]   flip_q, flip_d;
    logic [NSYM-1:0]   rot_q, rot_d;
    logic [NSYM-1:0]   pol_q, pol_d;

    logic              accept, advance, gen;
    logic [2*NSYM-1:0] src;
    logic              src_par;
    logic [3:0]        k;
    logic signed [1:0] rd_w;
    logic              prev_w, flip_s, pol_s, rot_s;
    logic [NSYM-1:0]   flip_v, rot_v, pol_v;

    assign in_ready = ~valid_q | (out_ready & last_q);
    assign accept   = in_valid & in_ready;
    // advance and accept are exclusive: advance needs a non-last beat, which holds in_ready low
    assign advance  = valid_q & out_ready & ~last_q;
    assign gen      = accept | advance;
    assign src      = accept ? Tx_Data : data_q;
    assign src_par  = accept ? par_mode : mode_q;
    assign k        = accept ? 4'd0 : idx_q + 4'd1;

    // Symbol generation: one selected symbol in serial mode, the whole chain in parallel mode
    always_comb begin
        rd_w   = rd_clr ? 2'sb00 : rd_q;
        prev_w = prev_rot_q;
        flip_s = 1'b0;
        pol_s  = 1'b0;
        rot_s  = 1'b0;
        flip_v = '0;
        rot_v  = '0;
        pol_v  = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (src_par || (i == int'(k))) begin
                flip_s = ((rd_w == RD_POS) & src[2*i]) | ((rd_w == RD_NEG) & ~src[2*i]);
                pol_s  = src[2*i] ^ flip_s;
                rot_s  = (DIFF_ROT != 0) ? (src[2*i+1] ^ prev_w) : src[2*i+1];
                prev_w = rot_s;
                rd_w   = pol_s ? (rd_w + RD_POS) : (rd_w - RD_POS);
                if (src_par) begin
                    flip_v[i] = flip_s;
                    rot_v[i]  = rot_s;
                    pol_v[i]  = pol_s;
                end else begin
                    flip_v[0] = flip_s;
                    rot_v[0]  = rot_s;
                    pol_v[0]  = pol_s;
                end
            end
        end
    end

    always_comb begin
        data_d     = data_q;
        mode_d     = mode_q;
        idx_d      = idx_q;
        rd_d       = rd_clr ? 2'sb00 : rd_q;
        prev_rot_d = prev_rot_q;
        valid_d    = valid_q;
        last_d     = last_q;
        flip_d     = flip_q;
        rot_d      = rot_q;
        pol_d      = pol_q;
        if (accept) begin
            data_d = Tx_Data;
            mode_d = par_mode;
        end
        if (gen) begin
            valid_d    = 1'b1;
            last_d     = src_par | (k == LAST_IDX);
            idx_d      = src_par ? 4'd0 : k;
            flip_d     = flip_v;
            rot_d      = rot_v;
            pol_d      = pol_v;
            rd_d       = rd_w;
            prev_rot_d = prev_w;
        end else if (valid_q & out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            idx_d   = 4'd0;
            flip_d  = '0;
            rot_d   = '0;
            pol_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            mode_q     <= 1'b0;
            idx_q      <= 4'd0;
            rd_q       <= 2'sb00;
            prev_rot_q <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            flip_q     <= '0;
            rot_q      <= '0;
            pol_q      <= '0;
        end else begin
            data_q     <= data_d;
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            rd_q       <= rd_d;
            prev_rot_q <= prev_rot_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            flip_q     <= flip_d;
            rot_q      <= rot_d;
            pol_q      <= pol_d;
        end
    end

    assign Tx_Flip     = flip_q;
    assign Tx_Rotation = rot_q;
    assign Tx_Polarity = pol_q;
    assign out_valid   = valid_q;
    assign out_last    = last_q;
    assign sym_idx     = idx_q;

endmodule

// File: tb/tb_frp_stream_encoder.sv
// Bench for frp_stream_encoder: plain and differential-rotation instances share stimulus.
module tb_frp_stream_encoder;
    localparam int NSYM = 7;

    logic clk = 1'b0;
    logic rst;
    logic [2*NSYM-1:0] Tx_Data;
    logic in_valid, par_mode, rd_clr, out_ready;
    logic in_ready, out_valid, out_last;
    logic [NSYM-1:0] Tx_Flip, Tx_Rotation, Tx_Polarity;
    logic [3:0] sym_idx;
    logic d_in_ready, d_out_valid, d_out_last;
    logic [NSYM-1:0] d_Tx_Flip, d_Tx_Rotation, d_Tx_Polarity;
    logic [3:0] d_sym_idx;

    frp_stream_encoder #(.NSYM(NSYM), .DIFF_ROT(0)) dut (
        .clk(clk), .rst(rst), .Tx_Data(Tx_Data), .in_valid(in_valid), .in_ready(in_ready),
        .par_mode(par_mode), .rd_clr(rd_clr), .Tx_Flip(Tx_Flip), .Tx_Rotation(Tx_Rotation),
        .Tx_Polarity(Tx_Polarity), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .sym_idx(sym_idx)
    );

    frp_stream_encoder #(.NSYM(NSYM), .DIFF_ROT(1)) dut_d (
        .clk(clk), .rst(rst), .Tx_Data(Tx_Data), .in_valid(in_valid), .in_ready(d_in_ready),
        .par_mode(par_mode), .rd_clr(rd_clr), .Tx_Flip(d_Tx_Flip), .Tx_Rotation(d_Tx_Rotation),
        .Tx_Polarity(d_Tx_Polarity), .out_valid(d_out_valid), .out_ready(out_ready),
        .out_last(d_out_last), .sym_idx(d_sym_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NSYM-1:0] flip;
        logic [NSYM-1:0] rot;
        logic [NSYM-1:0] rotd;
        logic [NSYM-1:0] pol;
        logic            last;
        logic [3:0]      idx;
        logic [1:0]      rd;
    } beat_t;

    beat_t sb_q[$];
    beat_t mon_b;
    int    pass_cnt = 0;
    int    total_cnt = 0;
    int    mon_beats = 0;
    int    m_rd = 0;
    logic  m_prev = 1'b0;

    // Reference model: expands one accepted word into its expected beats
    task automatic model_word(input logic [2*NSYM-1:0] w, input logic pm);
        beat_t b;
        logic rp, rr, fl, op;
        b = '0;
        for (int i = 0; i < NSYM; i++) begin
            rr = w[2*i+1];
            rp = w[2*i];
            fl = 1'b0;
            if (m_rd > 0 && rp) fl = 1'b1;
            if (m_rd < 0 && !rp) fl = 1'b1;
            op = fl ? ~rp : rp;
            m_rd = m_rd + (op ? 1 : -1);
            m_prev = rr ^ m_prev;
            if (pm) begin
                b.flip[i] = fl;
                b.rot[i]  = rr;
                b.rotd[i] = m_prev;
                b.pol[i]  = op;
            end else begin
                b = '0;
                b.flip[0] = fl;
                b.rot[0]  = rr;
                b.rotd[0] = m_prev;
                b.pol[0]  = op;
                b.idx     = 4'(i);
                b.last    = (i == NSYM - 1);
                b.rd      = 2'(m_rd);
                sb_q.push_back(b);
            end
        end
        if (pm) begin
            b.last = 1'b1;
            b.idx  = 4'd0;
            b.rd   = 2'(m_rd);
            sb_q.push_back(b);
        end
    endtask

    // Scoreboard monitor: pops on every transferred beat, pushes on every accepted word
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            m_rd = 0;
            m_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                total_cnt++;
                if (sb_q.size() == 0) begin
                    $display("FAIL beat_unexpected: got sym_idx=%0d, required no beat", sym_idx);
                end else begin
                    mon_b = sb_q.pop_front();
                    mon_beats++;
                    if ({Tx_Flip, Tx_Rotation, Tx_Polarity, out_last, sym_idx, dut.rd_q} !==
                        {mon_b.flip, mon_b.rot, mon_b.pol, mon_b.last, mon_b.idx, mon_b.rd})
                        $display("FAIL beat: got flip=%b rot=%b pol=%b last=%b idx=%0d rd=%b, required flip=%b rot=%b pol=%b last=%b idx=%0d rd=%b",
                                 Tx_Flip, Tx_Rotation, Tx_Polarity, out_last, sym_idx, dut.rd_q,
                                 mon_b.flip, mon_b.rot, mon_b.pol, mon_b.last, mon_b.idx, mon_b.rd);
                    else
                        pass_cnt++;
                    total_cnt++;
                    if ({d_out_valid, d_Tx_Flip, d_Tx_Rotation, d_Tx_Polarity, d_out_last, d_sym_idx} !==
                        {1'b1, mon_b.flip, mon_b.rotd, mon_b.pol, mon_b.last, mon_b.idx})
                        $display("FAIL beat_diffrot: got flip=%b rot=%b pol=%b last=%b idx=%0d, required flip=%b rot=%b pol=%b last=%b idx=%0d",
                                 d_Tx_Flip, d_Tx_Rotation, d_Tx_Polarity, d_out_last, d_sym_idx,
                                 mon_b.flip, mon_b.rotd, mon_b.pol, mon_b.last, mon_b.idx);
                    else
                        pass_cnt++;
                end
            end
            if (rd_clr) m_rd = 0;
            if (in_valid && in_ready) model_word(Tx_Data, par_mode);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send_word(input logic [2*NSYM-1:0] w, input logic pm, input logic clr);
        Tx_Data  = w;
        par_mode = pm;
        rd_clr   = clr;
        in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                rd_clr   = 1'b0;
                return;
            end
        end
        total_cnt++;
        $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required acceptance");
        in_valid = 1'b0;
        rd_clr   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (!out_valid && sb_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        total_cnt++;
        $display("FAIL idle_timeout: got out_valid=%b pending=%0d, required drained", out_valid, sb_q.size());
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({out_valid, out_last, Tx_Flip, Tx_Rotation, Tx_Polarity, sym_idx} !== '0)
            $display("FAIL reset_outputs: got v=%b l=%b f=%b r=%b p=%b idx=%0d, required all 0",
                     out_valid, out_last, Tx_Flip, Tx_Rotation, Tx_Polarity, sym_idx);
        else pass_cnt++;
        total_cnt++;
        if ({in_ready, d_in_ready, d_out_valid} !== 3'b110)
            $display("FAIL reset_ready: got in_ready=%b d_in_ready=%b d_out_valid=%b, required 1 1 0",
                     in_ready, d_in_ready, d_out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({dut.rd_q, dut_d.rd_q} !== 4'b0000)
            $display("FAIL reset_rd: got %b/%b, required 00/00", dut.rd_q, dut_d.rd_q);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_serial_ones();
        logic [6:0] f_seq, p_seq, r_seq, rd_seq, l_seq, v_seq;
        reset_dut();
        out_ready = 1'b1;
        send_word(14'h3FFF, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            v_seq[i]  = out_valid;
            f_seq[i]  = Tx_Flip[0];
            p_seq[i]  = Tx_Polarity[0];
            r_seq[i]  = Tx_Rotation[0];
            rd_seq[i] = d_Tx_Rotation[0];
            l_seq[i]  = out_last;
        end
        total_cnt++;
        if ({v_seq, f_seq, p_seq} !== {7'b1111111, 7'b0101010, 7'b1010101})
            $display("FAIL serial_ones_flip_pol: got v=%b f=%b p=%b, required v=1111111 f=0101010 p=1010101",
                     v_seq, f_seq, p_seq);
        else pass_cnt++;
        total_cnt++;
        if ({r_seq, l_seq} !== {7'b1111111, 7'b1000000})
            $display("FAIL serial_ones_rot_last: got rot=%b last=%b, required rot=1111111 last=1000000", r_seq, l_seq);
        else pass_cnt++;
        total_cnt++;
        if (rd_seq !== 7'b1010101)
            $display("FAIL diffrot_ones: got rot=%b, required 1010101", rd_seq);
        else pass_cnt++;
        wait_idle();
        total_cnt++;
        if (dut.rd_q !== 2'b01)
            $display("FAIL serial_ones_final_rd: got %b, required 01", dut.rd_q);
        else pass_cnt++;
    endtask

    task automatic test_parallel_zeros();
        reset_dut();
        out_ready = 1'b1;
        send_word(14'h0000, 1'b1, 1'b0);
        @(negedge clk);
        total_cnt++;
        if ({out_valid, Tx_Flip, Tx_Polarity, Tx_Rotation, out_last, sym_idx} !==
            {1'b1, 7'b0101010, 7'b0101010, 7'b0000000, 1'b1, 4'd0})
            $display("FAIL parallel_zeros: got v=%b f=%b p=%b r=%b l=%b idx=%0d, required v=1 f=0101010 p=0101010 r=0000000 l=1 idx=0",
                     out_valid, Tx_Flip, Tx_Polarity, Tx_Rotation, out_last, sym_idx);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL parallel_single_beat: got out_valid=%b, required 0", out_valid);
        else pass_cnt++;
        wait_idle();
        total_cnt++;
        if (dut.rd_q !== 2'b11)
            $display("FAIL parallel_final_rd: got %b, required 11", dut.rd_q);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int   nv = 0;
        logic ir6 = 1'b0;
        logic end_v = 1'b1;
        out_ready = 1'b1;
        fork
            begin
                send_word(14'h1234, 1'b0, 1'b0);
                send_word(14'h2B6D, 1'b0, 1'b0);
            end
            begin
                @(negedge clk);
                for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
                for (int b = 0; b < 14; b++) begin
                    if (out_valid) nv++;
                    if (b == 6) ir6 = in_ready;
                    @(negedge clk);
                end
                end_v = out_valid;
            end
        join
        total_cnt++;
        if (nv != 14)
            $display("FAIL b2b_beats: got %0d valid beats, required 14", nv);
        else pass_cnt++;
        total_cnt++;
        if ({ir6, end_v} !== 2'b10)
            $display("FAIL b2b_ready: got in_ready@beat7=%b valid@beat15=%b, required 1 0", ir6, end_v);
        else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_stall();
        reset_dut();
        out_ready = 1'b1;
        mon_beats = 0;
        send_word(14'h0F5A, 1'b0, 1'b0);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid && sym_idx == 4'd2) break;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if (sb_q.size() == 0)
                $display("FAIL stall_hold: got empty scoreboard, required pending beat");
            else if ({out_valid, Tx_Flip, Tx_Rotation, Tx_Polarity, out_last, sym_idx, dut.rd_q} !==
                     {1'b1, sb_q[0].flip, sb_q[0].rot, sb_q[0].pol, sb_q[0].last, sb_q[0].idx, sb_q[0].rd})
                $display("FAIL stall_hold: got v=%b f=%b p=%b idx=%0d rd=%b, required v=1 f=%b p=%b idx=%0d rd=%b",
                         out_valid, Tx_Flip, Tx_Polarity, sym_idx, dut.rd_q,
                         sb_q[0].flip, sb_q[0].pol, sb_q[0].idx, sb_q[0].rd);
            else pass_cnt++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({out_valid, sym_idx} !== {1'b1, 4'd3})
            $display("FAIL stall_resume: got v=%b idx=%0d, required v=1 idx=3", out_valid, sym_idx);
        else pass_cnt++;
        wait_idle();
        total_cnt++;
        if (mon_beats != 7)
            $display("FAIL stall_beat_count: got %0d, required 7", mon_beats);
        else pass_cnt++;
    endtask

    task automatic test_mode_hold_clr();
        reset_dut();
        out_ready = 1'b1;
        mon_beats = 0;
        send_word(14'h2A5C, 1'b0, 1'b0);
        par_mode = 1'b1;
        wait_idle();
        total_cnt++;
        if (mon_beats != 7)
            $display("FAIL mode_hold: got %0d beats, required 7 serial beats", mon_beats);
        else pass_cnt++;
        send_word(14'h1555, 1'b1, 1'b1);
        @(negedge clk);
        total_cnt++;
        if ({Tx_Flip, Tx_Polarity, Tx_Rotation} !== {7'b0101010, 7'b1010101, 7'b0000000})
            $display("FAIL rd_clr_parallel: got f=%b p=%b r=%b, required f=0101010 p=1010101 r=0000000",
                     Tx_Flip, Tx_Polarity, Tx_Rotation);
        else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_reset_midword();
        out_ready = 1'b1;
        send_word(14'h3FFF, 1'b0, 1'b0);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid && sym_idx == 4'd3) break;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({out_valid, out_last, Tx_Flip, Tx_Rotation, Tx_Polarity, sym_idx, dut.rd_q, in_ready} !==
            {1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 4'd0, 2'b00, 1'b1})
            $display("FAIL reset_midword: got v=%b l=%b f=%b r=%b p=%b idx=%0d rd=%b rdy=%b, required zeros and rdy=1",
                     out_valid, out_last, Tx_Flip, Tx_Rotation, Tx_Polarity, sym_idx, dut.rd_q, in_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(14'h3FFF, 1'b0, 1'b0);
        @(negedge clk);
        total_cnt++;
        if ({out_valid, sym_idx, Tx_Flip[0], Tx_Polarity[0]} !== {1'b1, 4'd0, 1'b0, 1'b1})
            $display("FAIL after_reset_word: got v=%b idx=%0d f=%b p=%b, required v=1 idx=0 f=0 p=1",
                     out_valid, sym_idx, Tx_Flip[0], Tx_Polarity[0]);
        else pass_cnt++;
        wait_idle();
    endtask

    task automatic test_random();
        bit done = 1'b0;
        fork
            begin
                for (int n = 0; n < 12; n++)
                    send_word(14'($urandom), 1'($urandom_range(0, 1)), 1'b0);
                done = 1'b1;
            end
            begin
                for (int t = 0; t < 3000 && !done; t++) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        Tx_Data = '0;
        par_mode = 1'b0;
        rd_clr = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_serial_ones();
        test_parallel_zeros();
        test_back_to_back();
        test_stall();
        test_mode_hold_clr();
        test_reset_midword();
        test_random();
        total_cnt++;
        if (sb_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d pending beats, required 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
